alu_iter: RTL

//   Multi-cycle RV32I ALU that consumes operand A (rs1) and operand B from the ALU B-input mux.

---
 rtl/alu_iter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle RV32I ALU with iterative (or single-cycle) shifter
// Define ALU_ITER_FAST_SHIFT_EN to replace the bit-serial shifter with a barrel shifter.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

`ifdef ALU_ITER_FAST_SHIFT_EN
    localparam bit ITERATIVE = 1'b0;
`else
    localparam bit ITERATIVE = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] acc_step;
    logic [SW-1:0]    shamt;
    logic             is_shift;

    // Single-cycle result for everything except a multi-bit iterative shift.
    function automatic logic [WIDTH-1:0] op_result(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
`ifdef ALU_ITER_FAST_SHIFT_EN
        logic [SW-1:0] sh;
        sh = y[SW-1:0];
`endif
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
`ifdef ALU_ITER_FAST_SHIFT_EN
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = WIDTH'($signed(x) >>> sh);
`else
            // Only reached with shamt==0 in the iterative build.
            OP_SLL, OP_SRL, OP_SRA: r = x;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {x[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, x[WIDTH-1:1]};
            OP_SRA:  r = {x[WIDTH-1], x[WIDTH-1:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        shamt    = b[SW-1:0];
        is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
        op_res   = op_result(alu_ctrl, a, b);
        acc_step = shift_one(ctrl_q, acc_q);
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        zero_d   = zero_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start like IDLE so ops can issue back-to-back.
                if (start) begin
                    ctrl_d = alu_ctrl;
                    if (ITERATIVE && is_shift && (shamt != '0)) begin
                        acc_d   = a;
                        count_d = shamt;
                        busy_d  = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_d   = acc_step;
                count_d = count_q - SW'(1);
                if (count_q == SW'(1)) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
